// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder for a pipelined core's MEM stage.
// Serializes accesses through IDLE -> BUSY -> DONE and flags misaligned/out-of-range accesses.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        MemErrM
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          fault;
  logic          finish;
  logic [AW-1:0] word_idx;

  assign fault    = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
  assign finish   = (state_q == StBusy) && (cnt_q == 4'd0);
  assign word_idx = addr_q[AW+1:2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      write_q   <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      ReadDataM <= 32'h0;
      MemReadyM <= 1'b0;
      MemErrM   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MemReqM) begin
            write_q <= MemWriteM;
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q   <= StDone;
            MemReadyM <= 1'b1;
            MemErrM   <= fault;
            if (fault) begin
              ReadDataM <= 32'h0;
            end else if (!write_q) begin
              ReadDataM <= mem[word_idx];
            end
          end
        end
        StDone: begin
          MemReadyM <= 1'b0;
          MemErrM   <= 1'b0;
          // A request still held in DONE is accepted here, as IDLE would on this edge.
          if (MemReqM) begin
            write_q <= MemWriteM;
            addr_q  <= ALUResultM;
            wdata_q <= WriteDataM;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StBusy;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage is deliberately not reset; a reset during BUSY leaves state IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (finish && write_q && !fault) begin
      mem[word_idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of accesses plus hand sequences for
// back-to-back, mid-access reset and latency sweep.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM, rd_l1, rd_l15;
  logic        MemReadyM, MemErrM, rdy_l1, err_l1, rdy_l15, err_l15;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemReadyM(MemReadyM), .MemErrM(MemErrM)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(rd_l1), .MemReadyM(rdy_l1), .MemErrM(err_l1)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) dut_l15 (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(rd_l15), .MemReadyM(rdy_l15), .MemErrM(err_l15)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // One access on the LATENCY=2 instance; inputs are scrambled after accept to show they are
  // ignored during BUSY. lat counts edges from accept to the first MemReadyM.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit hold, output int lat, output logic [31:0] rd,
                           output logic err, output int extra);
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = w; ALUResultM = a; WriteDataM = d;
    @(posedge clk); #1;
    MemWriteM = ~w; ALUResultM = ~a; WriteDataM = ~d;
    if (!hold) MemReqM = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!MemReadyM && lat < 40);
    rd  = ReadDataM;
    err = MemErrM;
    MemReqM = 1'b0;
    extra = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (MemReadyM || MemErrM) extra++;
    end
  endtask

  initial begin
    int          lat, extra;
    logic [31:0] rd;
    logic        err;
    int          first_l1, first_l2, first_l15, pulses_l1, pulses_l2, pulses_l15;

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h11111111, 1'b0};
    vecs[3]  = '{1'b0, 32'h4,   32'h0,        1'b1, 32'h22222222, 1'b0};
    vecs[4]  = '{1'b0, 32'h8,   32'h0,        1'b1, 32'h33333333, 1'b0};
    vecs[5]  = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h100, 32'hCAFEF00D, 1'b1, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h11111111, 1'b0};
    vecs[8]  = '{1'b1, 32'h20,  32'hA5A5A5A5, 1'b1, 32'h11111111, 1'b0};
    vecs[9]  = '{1'b0, 32'h20,  32'h0,        1'b1, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 32'hFC,  32'h0BADC0DE, 1'b1, 32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b0, 32'hFC,  32'h0,        1'b1, 32'h0BADC0DE, 1'b0};
    vecs[12] = '{1'b0, 32'h102, 32'h0,        1'b1, 32'h0,        1'b1};
    vecs[13] = '{1'b1, 32'h4,   32'h44444444, 1'b0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'h4,   32'h0,        1'b0, 32'h44444444, 1'b0};

    reset = 1'b1; MemReqM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    #1;
    check("reset_rdata", ReadDataM, 32'h0);
    check("reset_ready", 32'(MemReadyM), 32'h0);
    check("reset_err", 32'(MemErrM), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Back-to-back writes with MemReqM held: accepts at E0, E3, E6; DONE after E2, E5, E8.
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h0; WriteDataM = 32'h11111111;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_ready_e%0d", k), 32'(MemReadyM), 32'((k % 3) == 2));
      if (k == 0) begin ALUResultM = 32'h4; WriteDataM = 32'h22222222; end
      if (k == 3) begin ALUResultM = 32'h8; WriteDataM = 32'h33333333; end
      if (k == 8) MemReqM = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 check("b2b_ready_after", 32'(MemReadyM), 32'h0);

    for (int i = 0; i < 15; i++) begin
      do_access(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].hold, lat, rd, err, extra);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_no_extra_ready", i), 32'(extra), 32'd0);
    end

    // Reset during BUSY of a write to 0x20 must abort it and clear outputs at once.
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h20; WriteDataM = 32'h12345678;
    @(posedge clk); #1;
    MemReqM = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("midreset_rdata", ReadDataM, 32'h0);
    check("midreset_ready", 32'(MemReadyM), 32'h0);
    check("midreset_err", 32'(MemErrM), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_access(1'b0, 32'h20, 32'h0, 1'b1, lat, rd, err, extra);
    check("postreset_latency", 32'(lat), 32'd2);
    check("postreset_rdata", rd, 32'hA5A5A5A5);
    check("postreset_err", 32'(err), 32'h0);

    // Latency sweep: one read issued to all three instances, all idle.
    repeat (20) @(posedge clk);
    first_l1 = -1; first_l2 = -1; first_l15 = -1;
    pulses_l1 = 0; pulses_l2 = 0; pulses_l15 = 0;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0;
    @(posedge clk); #1;
    MemReqM = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rdy_l1) begin pulses_l1++; if (first_l1 < 0) first_l1 = c; end
      if (MemReadyM) begin pulses_l2++; if (first_l2 < 0) first_l2 = c; end
      if (rdy_l15) begin pulses_l15++; if (first_l15 < 0) first_l15 = c; end
    end
    check("sweep_l1_latency", 32'(first_l1), 32'd1);
    check("sweep_l2_latency", 32'(first_l2), 32'd2);
    check("sweep_l15_latency", 32'(first_l15), 32'd15);
    check("sweep_l1_pulses", 32'(pulses_l1), 32'd1);
    check("sweep_l15_pulses", 32'(pulses_l15), 32'd1);
    check("sweep_l2_pulses", 32'(pulses_l2), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
